status_flags_unit: RTL and testbench

- Processor status (P) register stage directly downstream of the ALU.
- Consumes ALU result, carry-out and overflow-out each cycle; updates N, Z, C, V under microcode control.
- Handles flag set/clear instructions, PLP/RTI load and interrupt-entry I set.
- Produces the P byte for stack pushes and the delayed IRQ mask used by interrupt polling.

---
 rtl/status_flags_unit.sv | 142 ++++++++++++++
 tb/tb_status_flags_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/status_flags_unit.sv
// Processor status (P) register stage behind the ALU: N,Z,C,I,D,V flags, P push byte, delayed IRQ mask.
// Latency: 1 cycle from any update input to the flag outputs; p_push is combinational from the flags and brk_push.
// Backpressure: none; every input is consumed on every clock edge.
//
// Ports: clk/rst (synchronous, active-high); ALU result/carry/overflow with upd_nz/upd_c/upd_v load enables;
//        bit_en (BIT op) and plp_load take operands from mem_in; flag_op_en/flag_op execute the set/clear
//        instructions; int_set_i sets I on interrupt entry; poll_strobe samples I into irq_mask;
//        flag_* are the registered flags, p_push is the stack image, irq_mask is the effective IRQ mask.
// Optional feature: define STATUS_DECIMAL_EN to store the D flag; otherwise D reads as 0 everywhere.
module status_flags_unit #(
    parameter bit RESET_I  = 1'b1,
    parameter bit BIT5_VAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] alu_res,
    input  logic       alu_cout,
    input  logic       alu_ovf,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bit_en,
    input  logic [7:0] mem_in,
    input  logic       plp_load,
    input  logic       flag_op_en,
    input  logic [2:0] flag_op,
    input  logic       int_set_i,
    input  logic       brk_push,
    input  logic       poll_strobe,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_i,
    output logic       flag_d,
    output logic       flag_v,
    output logic       flag_n,
    output logic [7:0] p_push,
    output logic       irq_mask
);

    localparam logic [2:0] OP_CLC = 3'd0;
    localparam logic [2:0] OP_SEC = 3'd1;
    localparam logic [2:0] OP_CLI = 3'd2;
    localparam logic [2:0] OP_SEI = 3'd3;
    localparam logic [2:0] OP_CLV = 3'd4;

    logic r_c, r_z, r_i, r_v, r_n, r_irq_mask;
    logic w_c_nxt, w_z_nxt, w_i_nxt, w_v_nxt, w_n_nxt;
    logic w_d;
    logic w_alu_zero;
    logic w_unused_mem;

    // Full-width zero detect; BIT and upd_nz share it.
    assign w_alu_zero = (alu_res == 8'h00);

    // Each flag is an independent priority chain, highest priority tested first.
    always_comb begin
        w_c_nxt = r_c;
        w_z_nxt = r_z;
        w_i_nxt = r_i;
        w_v_nxt = r_v;
        w_n_nxt = r_n;

        if (plp_load)                                w_c_nxt = mem_in[0];
        else if (flag_op_en && flag_op == OP_CLC)    w_c_nxt = 1'b0;
        else if (flag_op_en && flag_op == OP_SEC)    w_c_nxt = 1'b1;
        else if (upd_c)                              w_c_nxt = alu_cout;

        if (plp_load)                                w_z_nxt = mem_in[1];
        else if (bit_en || upd_nz)                   w_z_nxt = w_alu_zero;

        if (plp_load)                                w_i_nxt = mem_in[2];
        else if (int_set_i)                          w_i_nxt = 1'b1;
        else if (flag_op_en && flag_op == OP_CLI)    w_i_nxt = 1'b0;
        else if (flag_op_en && flag_op == OP_SEI)    w_i_nxt = 1'b1;

        if (plp_load)                                w_v_nxt = mem_in[6];
        else if (flag_op_en && flag_op == OP_CLV)    w_v_nxt = 1'b0;
        else if (bit_en)                             w_v_nxt = mem_in[6];
        else if (upd_v)                              w_v_nxt = alu_ovf;

        if (plp_load)                                w_n_nxt = mem_in[7];
        else if (bit_en)                             w_n_nxt = mem_in[7];
        else if (upd_nz)                             w_n_nxt = alu_res[7];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c        <= 1'b0;
            r_z        <= 1'b0;
            r_i        <= RESET_I;
            r_v        <= 1'b0;
            r_n        <= 1'b0;
            r_irq_mask <= RESET_I;
        end else begin
            r_c <= w_c_nxt;
            r_z <= w_z_nxt;
            r_i <= w_i_nxt;
            r_v <= w_v_nxt;
            r_n <= w_n_nxt;
            // Pre-edge I is sampled, so a CLI/SEI/PLP only reaches the mask at the following poll.
            if (poll_strobe) r_irq_mask <= r_i;
        end
    end

`ifdef STATUS_DECIMAL_EN
    localparam logic [2:0] OP_CLD = 3'd5;
    localparam logic [2:0] OP_SED = 3'd6;

    logic r_d;
    logic w_d_nxt;

    always_comb begin
        w_d_nxt = r_d;
        if (plp_load)                                w_d_nxt = mem_in[3];
        else if (flag_op_en && flag_op == OP_CLD)    w_d_nxt = 1'b0;
        else if (flag_op_en && flag_op == OP_SED)    w_d_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_d <= 1'b0;
        else     r_d <= w_d_nxt;
    end

    assign w_d          = r_d;
    assign w_unused_mem = ^mem_in[5:4];
`else
    assign w_d          = 1'b0;
    assign w_unused_mem = ^mem_in[5:3];
`endif

    assign flag_c   = r_c;
    assign flag_z   = r_z;
    assign flag_i   = r_i;
    assign flag_d   = w_d;
    assign flag_v   = r_v;
    assign flag_n   = r_n;
    assign irq_mask = r_irq_mask;

    // Bit 4 (B) is never stored: it exists only in the pushed image.
    assign p_push = {r_n, r_v, BIT5_VAL, brk_push, w_d, r_i, r_z, r_c};

endmodule

// File: tb/tb_status_flags_unit.sv
module tb_status_flags_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_res;
    logic       alu_cout, alu_ovf, upd_nz, upd_c, upd_v, bit_en;
    logic [7:0] mem_in;
    logic       plp_load, flag_op_en;
    logic [2:0] flag_op;
    logic       int_set_i, brk_push, poll_strobe;
    logic       flag_c, flag_z, flag_i, flag_d, flag_v, flag_n;
    logic [7:0] p_push;
    logic       irq_mask;

`ifdef STATUS_DECIMAL_EN
    localparam bit HAS_D = 1'b1;
`else
    localparam bit HAS_D = 1'b0;
`endif

    status_flags_unit #(.RESET_I(1'b1), .BIT5_VAL(1'b1)) dut (
        .clk(clk), .rst(rst), .alu_res(alu_res), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
        .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_en(bit_en), .mem_in(mem_in),
        .plp_load(plp_load), .flag_op_en(flag_op_en), .flag_op(flag_op), .int_set_i(int_set_i),
        .brk_push(brk_push), .poll_strobe(poll_strobe),
        .flag_c(flag_c), .flag_z(flag_z), .flag_i(flag_i), .flag_d(flag_d), .flag_v(flag_v),
        .flag_n(flag_n), .p_push(p_push), .irq_mask(irq_mask)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state: P byte in stack layout (bit 0 C, 1 Z, 2 I, 3 D, 6 V, 7 N; bits 4,5 kept 0).
    logic [7:0] m_p;
    logic       m_mask;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply updates lowest priority first so that later (higher priority) writes overwrite.
    always @(posedge clk) begin
        logic [7:0] np;
        np = m_p;
        if (upd_c)  np[0] = alu_cout;
        if (upd_v)  np[6] = alu_ovf;
        if (upd_nz) begin np[7] = alu_res[7]; np[1] = (alu_res == 8'h00); end
        if (bit_en) begin np[7] = mem_in[7]; np[6] = mem_in[6]; np[1] = (alu_res == 8'h00); end
        if (flag_op_en) begin
            case (flag_op)
                3'd0: np[0] = 1'b0;
                3'd1: np[0] = 1'b1;
                3'd2: np[2] = 1'b0;
                3'd3: np[2] = 1'b1;
                3'd4: np[6] = 1'b0;
                3'd5: if (HAS_D) np[3] = 1'b0;
                3'd6: if (HAS_D) np[3] = 1'b1;
                default: ;
            endcase
        end
        if (int_set_i) np[2] = 1'b1;
        if (plp_load) begin
            np = mem_in & 8'hCF;
            if (!HAS_D) np[3] = 1'b0;
        end
        if (poll_strobe) m_mask = m_p[2];
        m_p = np;
        if (rst) begin
            m_p    = 8'h04;
            m_mask = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_flag_c",   {7'd0, flag_c},   {7'd0, m_p[0]});
            chk("cyc_flag_z",   {7'd0, flag_z},   {7'd0, m_p[1]});
            chk("cyc_flag_i",   {7'd0, flag_i},   {7'd0, m_p[2]});
            chk("cyc_flag_d",   {7'd0, flag_d},   {7'd0, m_p[3]});
            chk("cyc_flag_v",   {7'd0, flag_v},   {7'd0, m_p[6]});
            chk("cyc_flag_n",   {7'd0, flag_n},   {7'd0, m_p[7]});
            chk("cyc_irq_mask", {7'd0, irq_mask}, {7'd0, m_mask});
            chk("cyc_p_push",   p_push,           m_p | 8'h20 | {3'b000, brk_push, 4'b0000});
        end
    end

    task automatic clr();
        rst = 1'b0; alu_res = 8'h00; alu_cout = 1'b0; alu_ovf = 1'b0;
        upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0; bit_en = 1'b0; mem_in = 8'h00;
        plp_load = 1'b0; flag_op_en = 1'b0; flag_op = 3'd7; int_set_i = 1'b0;
        brk_push = 1'b0; poll_strobe = 1'b0;
    endtask

    // Let the currently driven vector be captured by the next edge, then idle the inputs.
    task automatic go();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic fop(input logic [2:0] op);
        flag_op_en = 1'b1;
        flag_op    = op;
        go();
    endtask

    initial begin
        m_p    = 8'h00;
        m_mask = 1'b0;
        clr();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        clr();
        brk_push = 1'b1;
        @(negedge clk);
        chk("rst_p_push", p_push, 8'h34);
        chk("rst_flag_i", {7'd0, flag_i}, 8'h01);
        chk("rst_irq_mask", {7'd0, irq_mask}, 8'h01);
        chk("rst_nzcv", {4'd0, flag_n, flag_z, flag_c, flag_v}, 8'h00);

        // ALU update with a zero result, carry and overflow.
        alu_res = 8'h00; alu_cout = 1'b1; alu_ovf = 1'b1; upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1;
        go();
        @(negedge clk);
        chk("alu_nzcv", {4'd0, flag_n, flag_z, flag_c, flag_v}, 8'b0000_0111);

        // BIT outranks upd_nz and upd_v.
        bit_en = 1'b1; mem_in = 8'hC0; alu_res = 8'h00; upd_nz = 1'b1; upd_v = 1'b1; alu_ovf = 1'b0;
        go();
        @(negedge clk);
        chk("bit_nzv", {5'd0, flag_n, flag_z, flag_v}, 8'b0000_0111);

        // Full-width zero detect: a lone high-nibble bit is non-zero.
        alu_res = 8'h10; upd_nz = 1'b1;
        go();
        @(negedge clk);
        chk("z_partial", {6'd0, flag_n, flag_z}, 8'h00);

        alu_res = 8'h80; upd_nz = 1'b1; upd_c = 1'b1; alu_cout = 1'b0;
        go();
        @(negedge clk);
        chk("n_set_c_clr", {6'd0, flag_n, flag_c}, 8'b0000_0010);

        // PLP outranks a simultaneous CLC and ALU carry load.
        plp_load = 1'b1; mem_in = 8'hFF; flag_op_en = 1'b1; flag_op = 3'd0; upd_c = 1'b1;
        go();
        @(negedge clk);
        chk("plp_p_push", p_push, HAS_D ? 8'hEF : 8'hE7);
        chk("plp_flags", {2'd0, flag_n, flag_v, flag_d, flag_i, flag_z, flag_c},
            HAS_D ? 8'h3F : 8'h37);

        // CLI together with poll: mask takes old I, new I reaches the mask at the next poll.
        flag_op_en = 1'b1; flag_op = 3'd2; poll_strobe = 1'b1;
        go();
        @(negedge clk);
        chk("cli_poll_i", {7'd0, flag_i}, 8'h00);
        chk("cli_poll_mask", {7'd0, irq_mask}, 8'h01);
        poll_strobe = 1'b1;
        go();
        @(negedge clk);
        chk("next_poll_mask", {7'd0, irq_mask}, 8'h00);

        // Interrupt entry beats CLI.
        int_set_i = 1'b1; flag_op_en = 1'b1; flag_op = 3'd2;
        go();
        @(negedge clk);
        chk("int_vs_cli_i", {7'd0, flag_i}, 8'h01);
        chk("int_mask_hold", {7'd0, irq_mask}, 8'h00);

        // Remaining flag ops.
        fop(3'd4);
        fop(3'd1);
        fop(3'd6);
        @(negedge clk);
        chk("clv_sec_sed", {5'd0, flag_v, flag_c, flag_d}, {5'd0, 1'b0, 1'b1, HAS_D});
        fop(3'd5);
        fop(3'd0);
        fop(3'd3);
        fop(3'd7);
        @(negedge clk);
        chk("cld_clc", {6'd0, flag_d, flag_c}, 8'h00);

        // Reset overrides a simultaneous ALU update.
        rst = 1'b1; alu_res = 8'h80; upd_nz = 1'b1;
        go();
        @(negedge clk);
        chk("rst_override", {6'd0, flag_n, flag_i}, 8'h01);
        chk("rst_override_mask", {7'd0, irq_mask}, 8'h01);

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
